// File: rtl/wreq_chan_mngr.sv
// Write-request queue: accepts line writes, issues them on AXI AW, then hands each to the W stage in order.
// Latency: push to awvalid 1 cycle; AW accept to next_rq 2 cycles; finish_wd to next next_rq >= 2 cycles.
// Backpressure: wreq_ready drops when DEPTH entries are held; AW holds on awready=0; W-stage waits on finish_wd.
module wreq_chan_mngr #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wreq_valid,
    output logic         wreq_ready,
    input  logic [31:0]  wreq_addr,
    input  logic [3:0]   wreq_id,
    input  logic [127:0] wreq_wdata,
    input  logic [15:0]  wreq_mask,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  awaddr,
    output logic [3:0]   awid,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         next_rq,
    output logic [3:0]   next_id,
    output logic [127:0] next_wdata,
    output logic [15:0]  next_mask,
    input  logic         finish_wd,
    input  logic [3:0]   finish_id,
    output logic         id_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;

    localparam logic [1:0] WD_IDLE = 2'd0;
    localparam logic [1:0] WD_RQ   = 2'd1;
    localparam logic [1:0] WD_BUSY = 2'd2;

    typedef struct packed {
        logic [27:0]  addr;
        logic [3:0]   id;
        logic [127:0] wdata;
        logic [15:0]  mask;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PW-1:0] wr_ptr, aw_ptr, wd_ptr;
    logic [PW:0]   count, n_aw, n_wd;
    logic [1:0]    wd_state, wd_state_nxt;
    logic          push, aw_fire, free;

    // Ready comes from the registered count only, so there is no path from wreq_valid.
    assign wreq_ready = (count < FULL_CNT);
    assign push       = wreq_valid & wreq_ready;
    assign awvalid    = (n_aw != '0);
    assign aw_fire    = awvalid & awready;
    assign free       = (wd_state == WD_BUSY) & finish_wd;
    assign n_wd       = count - n_aw;

    assign awaddr  = {mem[aw_ptr].addr, 4'h0};
    assign awid    = mem[aw_ptr].id;
    assign awlen   = 8'd3;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;

    // The W-head entry cannot be overwritten until it is freed, so these stay stable through finish_wd.
    assign next_rq    = (wd_state == WD_RQ);
    assign next_id    = mem[wd_ptr].id;
    assign next_wdata = mem[wd_ptr].wdata;
    assign next_mask  = mem[wd_ptr].mask;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: wreq_addr[31:4], id: wreq_id, wdata: wreq_wdata, mask: wreq_mask};
        end
    end

    always_comb begin
        wd_state_nxt = WD_IDLE;
        case (wd_state)
            WD_IDLE: wd_state_nxt = (n_wd != '0) ? WD_RQ : WD_IDLE;
            WD_RQ:   wd_state_nxt = WD_BUSY;
            WD_BUSY: wd_state_nxt = finish_wd ? WD_IDLE : WD_BUSY;
            default: wd_state_nxt = WD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            aw_ptr   <= '0;
            wd_ptr   <= '0;
            count    <= '0;
            n_aw     <= '0;
            wd_state <= WD_IDLE;
            id_err   <= 1'b0;
        end else begin
            wd_state <= wd_state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (aw_fire) begin
                aw_ptr <= aw_ptr + PTR_ONE;
            end
            if (free) begin
                wd_ptr <= wd_ptr + PTR_ONE;
            end
            case ({push, aw_fire})
                2'b10:   n_aw <= n_aw + CNT_ONE;
                2'b01:   n_aw <= n_aw - CNT_ONE;
                default: n_aw <= n_aw;
            endcase
            case ({push, free})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (free && (finish_id != next_id)) begin
                id_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wreq_chan_mngr.sv
// Scoreboard bench for wreq_chan_mngr: random and directed writes checked against a queue-level model.
module tb_wreq_chan_mngr;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wreq_valid = 1'b0;
    logic         wreq_ready;
    logic [31:0]  wreq_addr = '0;
    logic [3:0]   wreq_id = '0;
    logic [127:0] wreq_wdata = '0;
    logic [15:0]  wreq_mask = '0;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  awaddr;
    logic [3:0]   awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         next_rq;
    logic [3:0]   next_id;
    logic [127:0] next_wdata;
    logic [15:0]  next_mask;
    logic         finish_wd = 1'b0;
    logic [3:0]   finish_id = '0;
    logic         id_err;

    wreq_chan_mngr #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr),
        .wreq_id(wreq_id), .wreq_wdata(wreq_wdata), .wreq_mask(wreq_mask),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .next_rq(next_rq), .next_id(next_id), .next_wdata(next_wdata), .next_mask(next_mask),
        .finish_wd(finish_wd), .finish_id(finish_id), .id_err(id_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [3:0]   id;
        logic [127:0] wdata;
        logic [15:0]  mask;
        int           cyc;
    } exp_t;

    exp_t aw_q[$];
    exp_t w_q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mcount = 0;
    bit   active = 0;
    bit   exp_err = 0;
    int   last_fin = -10;

    int   aw_mode = 0;
    int   rmin = 1;
    int   rmax = 3;
    bit   bad_next = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, where all inputs and outputs are settled.
    initial begin : mon
        exp_t e;
        bit   rdy_m;
        bit   busy_b;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                rdy_m  = (mcount < DEPTH);
                busy_b = active;
                chk("wreq_ready", wreq_ready, rdy_m);
                chk("id_err", id_err, exp_err);
                chk("awvalid", awvalid, aw_q.size() != 0);
                if (awvalid && aw_q.size() != 0) begin
                    e = aw_q[0];
                    chk("awaddr", awaddr, e.addr & 32'hFFFF_FFF0);
                    chk("awid", awid, e.id);
                    chk("awlen", awlen, 8'd3);
                    chk("awsize", awsize, 3'd2);
                    chk("awburst", awburst, 2'b01);
                    if (awready) begin
                        void'(aw_q.pop_front());
                        e.cyc = cyc;
                        w_q.push_back(e);
                    end
                end
                if (next_rq) begin
                    chk("rq_while_busy", active, 1'b0);
                    chk("rq_gap", (cyc - last_fin) >= 2, 1'b1);
                    if (w_q.size() == 0) begin
                        chk("rq_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = w_q.pop_front();
                        chk("rq_after_aw", e.cyc < cyc, 1'b1);
                        chk("next_id", next_id, e.id);
                        chk("next_wdata", next_wdata, e.wdata);
                        chk("next_mask", next_mask, e.mask);
                        cur = e;
                        active = 1;
                    end
                end else if (busy_b) begin
                    chk("hold_id", next_id, cur.id);
                    chk("hold_wdata", next_wdata, cur.wdata);
                    chk("hold_mask", next_mask, cur.mask);
                end
                if (finish_wd && busy_b) begin
                    if (finish_id != cur.id) exp_err = 1;
                    active = 0;
                    last_fin = cyc;
                    mcount--;
                end
                if (wreq_valid && rdy_m) begin
                    aw_q.push_back('{addr: wreq_addr, id: wreq_id, wdata: wreq_wdata,
                                     mask: wreq_mask, cyc: cyc});
                    mcount++;
                end
            end
        end
    end

    // W-side responder: answers each next_rq with finish_wd after rmin..rmax cycles.
    initial begin : resp
        int       rcnt;
        logic [3:0] rid;
        rcnt = 0;
        rid = '0;
        forever begin
            @(posedge clk);
            #1;
            finish_wd = 1'b0;
            if (!rst_n) begin
                rcnt = 0;
            end else begin
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        finish_wd = 1'b1;
                        finish_id = (bad_next && rid == 4'd2) ? 4'd7 : rid;
                    end
                end
                if (next_rq) begin
                    rid = next_id;
                    rcnt = $urandom_range(rmax, rmin);
                end
            end
        end
    end

    initial begin : awdrv
        forever begin
            @(posedge clk);
            #1;
            case (aw_mode)
                0:       awready = 1'b0;
                1:       awready = 1'b1;
                default: awready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    task automatic push_one(input logic [31:0] a, input logic [3:0] id,
                            input logic [127:0] d, input logic [15:0] m);
        bit ok;
        wreq_valid = 1'b1;
        wreq_addr = a;
        wreq_id = id;
        wreq_wdata = d;
        wreq_mask = m;
        ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = wreq_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("push_timeout", 1'b0, 1'b1);
        wreq_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int t = 0; t < 600 && !done; t++) begin
            @(posedge clk);
            #2;
            done = (aw_q.size() == 0 && w_q.size() == 0 && !active && mcount == 0);
        end
        if (!done) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_next_rq", next_rq, 1'b0);
        chk("rst_wreq_ready", wreq_ready, 1'b1);
        chk("rst_id_err", id_err, 1'b0);
        aw_q.delete();
        w_q.delete();
        mcount = 0;
        active = 0;
        exp_err = 0;
        last_fin = cyc - 10;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : main
        bit seen;
        do_reset();

        // single write
        aw_mode = 1; rmin = 1; rmax = 3;
        push_one(32'h1000_0014, 4'd5, 128'h44444444_33333333_22222222_11111111, 16'h0000);
        wait_drain();

        // fill with AW blocked, fifth write held until a slot frees
        aw_mode = 0;
        for (int i = 0; i < 4; i++) push_one(32'h2000_0000 + 32'(i * 16), 4'(i), rnd128(), 16'(i));
        wreq_valid = 1'b1;
        wreq_id = 4'd4;
        repeat (3) begin
            @(negedge clk);
            chk("full_ready", wreq_ready, 1'b0);
        end
        aw_mode = 1;
        push_one(32'h2000_0040, 4'd4, rnd128(), 16'hFFFF);
        wait_drain();

        // AW runs ahead while W is stalled
        rmin = 15; rmax = 15;
        for (int i = 0; i < 4; i++) push_one(32'h3000_0000 + 32'(i * 16), 4'(i + 8), rnd128(), $urandom);
        wait_drain();

        // wrap: ten back-to-back writes
        rmin = 1; rmax = 2;
        for (int i = 0; i < 10; i++) push_one($urandom, 4'(i), rnd128(), $urandom);
        wait_drain();

        // id mismatch is sticky and the queue keeps running
        bad_next = 1;
        for (int i = 0; i < 4; i++) push_one($urandom, 4'(i), rnd128(), $urandom);
        wait_drain();
        bad_next = 0;
        push_one($urandom, 4'd9, rnd128(), $urandom);
        wait_drain();
        chk("id_err_sticky", id_err, 1'b1);

        // reset while a burst is in flight with three more queued
        rmin = 30; rmax = 30;
        for (int i = 0; i < 4; i++) push_one($urandom, 4'(i), rnd128(), $urandom);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(posedge clk);
            #2;
            seen = active;
        end
        chk("busy_reached", seen, 1'b1);
        repeat (3) @(posedge clk);
        do_reset();
        rmin = 1; rmax = 3;
        push_one(32'h1000_0014, 4'd5, 128'h44444444_33333333_22222222_11111111, 16'h0000);
        wait_drain();

        // random traffic
        aw_mode = 2; rmin = 1; rmax = 6;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3, 0) != 0) begin
                push_one($urandom, 4'($urandom), rnd128(), 16'($urandom));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        aw_mode = 1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
